// File: rtl/tinyml_pkg.sv
// Shared types for the tinyML accelerator control path: opcode set,
// sequencer state encoding and the legal-opcode check.
package tinyml_pkg;

    typedef enum logic [4:0] {
        LOAD_V = 5'd1,
        LOAD_M = 5'd2,
        STORE  = 5'd3,
        GEMV   = 5'd4,
        RELU   = 5'd5
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_TRAP
    } seq_state_t;

    // True when the 5-bit opcode field names an instruction the execution unit implements.
    function automatic logic is_legal_opcode(input logic [4:0] op);
        case (op)
            LOAD_V, LOAD_M, STORE, GEMV, RELU: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO used as the instruction prefetch queue.
// A pop and a push in the same cycle are both honoured, even when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Top-level control for the tinyML accelerator: owns the PC, prefetches
// instructions into a queue, issues them to the execution unit, traps on
// illegal opcodes, supports single-step and arbitrates the DRAM port.
module program_sequencer
    import tinyml_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 24,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned INSTR_WIDTH = 64,
    parameter int unsigned PQ_DEPTH    = 4,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_pc,
    input  logic                   step_mode,
    output logic                   fetch_en,
    output logic [ADDR_WIDTH-1:0]  fetch_addr,
    input  logic                   fetch_done,
    input  logic [INSTR_WIDTH-1:0] fetch_instr,
    output logic                   exec_start,
    output logic [INSTR_WIDTH-1:0] exec_instr,
    input  logic                   exec_done,
    input  logic                   f_mem_req,
    input  logic [ADDR_WIDTH-1:0]  f_mem_addr,
    output logic                   f_mem_valid,
    input  logic                   e_mem_req,
    input  logic                   e_mem_we,
    input  logic [ADDR_WIDTH-1:0]  e_mem_addr,
    input  logic [DATA_WIDTH-1:0]  e_mem_wdata,
    output logic                   e_mem_valid,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_we,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   done,
    output logic                   trap,
    output logic [ADDR_WIDTH-1:0]  trap_pc,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   retired_count
);
    localparam int unsigned FIFO_W = INSTR_WIDTH + ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PC_STRIDE = ADDR_WIDTH'(INSTR_WIDTH / 8);

    seq_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, trap_pc_q;
    logic [INSTR_WIDTH-1:0]  exec_instr_q;
    logic [CNT_WIDTH-1:0]    retired_q;
    logic                    outstanding_q, halt_q, exec_busy_q, exec_start_q, done_q;
    logic                    e_valid_q, f_valid_q;

    logic                    fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
    logic [FIFO_W-1:0]       fifo_wdata, fifo_rdata;
    logic [INSTR_WIDTH-1:0]  head_instr;
    logic [ADDR_WIDTH-1:0]   head_pc;
    logic                    start_run, fetch_ret, can_issue, head_legal, issue_ok, issue_bad, retire;

    assign {head_pc, head_instr} = fifo_rdata;
    assign head_legal = is_legal_opcode(head_instr[4:0]);
    assign start_run  = start && (state_q == S_IDLE || state_q == S_TRAP);
    assign fetch_ret  = fetch_done && outstanding_q;
    // Traps are taken only with the execution unit idle so the trap point is precise.
    assign can_issue  = (state_q == S_RUN) && !fifo_empty && !exec_busy_q;
    assign issue_ok   = can_issue && head_legal;
    assign issue_bad  = can_issue && !head_legal;
    assign retire     = exec_done && exec_busy_q;

    // A fetch landing after a trap is drained but never queued.
    assign fifo_push  = fetch_ret && (fetch_instr != '0) && (state_q != S_TRAP);
    assign fifo_wdata = {pc_q, fetch_instr};
    assign fifo_pop   = issue_ok;
    assign fifo_flush = start_run || issue_bad;

    sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (PQ_DEPTH)
    ) u_pq (
        .clk     (clk),
        .rst     (rst),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_TRAP: if (start) state_d = S_RUN;
            S_RUN: begin
                if (issue_bad)                                  state_d = S_TRAP;
                else if (retire && step_mode)                   state_d = S_PAUSE;
                else if (halt_q && fifo_empty && !exec_busy_q)  state_d = S_IDLE;
            end
            S_PAUSE: if (start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // State-derived outputs; with one fetch in flight at most, the credit check reduces to !full.
    always_comb begin
        busy     = (state_q == S_RUN) || (state_q == S_PAUSE);
        trap     = (state_q == S_TRAP);
        fetch_en = (state_q == S_RUN) && !halt_q && !outstanding_q && !fifo_full && !issue_bad;
    end

    // PC, fetch tracking, issue/retire bookkeeping and registered grants.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= '0;
            trap_pc_q     <= '0;
            exec_instr_q  <= '0;
            retired_q     <= '0;
            outstanding_q <= 1'b0;
            halt_q        <= 1'b0;
            exec_busy_q   <= 1'b0;
            exec_start_q  <= 1'b0;
            done_q        <= 1'b0;
            e_valid_q     <= 1'b0;
            f_valid_q     <= 1'b0;
        end else begin
            exec_start_q <= issue_ok;
            done_q       <= (state_q == S_RUN) && (state_d == S_IDLE);
            e_valid_q    <= e_mem_req;
            f_valid_q    <= f_mem_req && !e_mem_req;
            if (start_run) begin
                pc_q          <= start_pc;
                retired_q     <= '0;
                halt_q        <= 1'b0;
                outstanding_q <= 1'b0;
            end else begin
                if (fetch_en) outstanding_q <= 1'b1;
                if (fetch_ret) begin
                    outstanding_q <= 1'b0;
                    pc_q          <= pc_q + PC_STRIDE;
                    if (fetch_instr == '0) halt_q <= 1'b1;
                end
                if (retire) retired_q <= retired_q + CNT_WIDTH'(1);
            end
            if (issue_bad) trap_pc_q <= head_pc;
            if (issue_ok) begin
                exec_instr_q <= head_instr;
                exec_busy_q  <= 1'b1;
            end else if (retire) begin
                exec_busy_q  <= 1'b0;
            end
        end
    end

    // DRAM port mux: exec side wins whenever it requests.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (e_mem_req) begin
            mem_addr  = e_mem_addr;
            mem_we    = e_mem_we;
            mem_wdata = e_mem_wdata;
        end else if (f_mem_req) begin
            mem_addr  = f_mem_addr;
        end
    end

    assign fetch_addr    = pc_q;
    assign exec_start    = exec_start_q;
    assign exec_instr    = exec_instr_q;
    assign done          = done_q;
    assign trap_pc       = trap_pc_q;
    assign retired_count = retired_q;
    assign e_mem_valid   = e_valid_q;
    assign f_mem_valid   = f_valid_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a behavioural fetch/exec responder
// and a scoreboard of expected issued instructions and fetch addresses.
module tb_program_sequencer;
    import tinyml_pkg::*;

    localparam int unsigned AW = 24;
    localparam int unsigned DW = 8;
    localparam int unsigned IW = 64;
    localparam int unsigned PQ = 4;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst, start, step_mode;
    logic [AW-1:0] start_pc;
    logic          fetch_en, fetch_done;
    logic [AW-1:0] fetch_addr;
    logic [IW-1:0] fetch_instr;
    logic          exec_start, exec_done;
    logic [IW-1:0] exec_instr;
    logic          f_mem_req, f_mem_valid, e_mem_req, e_mem_we, e_mem_valid;
    logic [AW-1:0] f_mem_addr, e_mem_addr, mem_addr;
    logic [DW-1:0] e_mem_wdata, mem_wdata;
    logic          mem_we, done, trap, busy;
    logic [AW-1:0] trap_pc;
    logic [CW-1:0] retired_count;

    always #5 clk = ~clk;

    program_sequencer #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .INSTR_WIDTH (IW),
        .PQ_DEPTH    (PQ),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc), .step_mode(step_mode),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_done(fetch_done), .fetch_instr(fetch_instr),
        .exec_start(exec_start), .exec_instr(exec_instr), .exec_done(exec_done),
        .f_mem_req(f_mem_req), .f_mem_addr(f_mem_addr), .f_mem_valid(f_mem_valid),
        .e_mem_req(e_mem_req), .e_mem_we(e_mem_we), .e_mem_addr(e_mem_addr), .e_mem_wdata(e_mem_wdata),
        .e_mem_valid(e_mem_valid), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .done(done), .trap(trap), .trap_pc(trap_pc), .busy(busy), .retired_count(retired_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n_exec = 0, n_fetch = 0, n_done = 0, n_extra = 0;
    int exec_cnt = 0, fetch_cnt = 0, exec_lat = 5;
    int base_e, base_f, base_d;
    logic          stray = 1'b0;
    logic [AW-1:0] fetch_a;
    logic [IW-1:0] prog [0:63];
    logic [IW-1:0] exp_q [$];
    logic [AW-1:0] exp_addr_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [4:0] op, input logic [7:0] tag);
        return {8'hA5, 40'h0, tag, 3'b000, op};
    endfunction

    task automatic put(input int unsigned addr, input logic [63:0] ins, input bit expect_issue);
        prog[addr / 8] = ins;
        if (expect_issue) exp_q.push_back(ins);
    endtask

    // One negedge: observe DUT outputs, then drive responder inputs for the next posedge.
    task automatic tick();
        @(negedge clk);
        if (exec_start) begin
            n_exec++;
            exec_cnt = exec_lat;
            if (exp_q.size() > 0) check("exec_instr", exec_instr, exp_q.pop_front());
            else n_extra++;
        end
        if (fetch_en) begin
            n_fetch++;
            fetch_a   = fetch_addr;
            fetch_cnt = 2;
            if (exp_addr_q.size() > 0) check("fetch_addr", 64'(fetch_addr), 64'(exp_addr_q.pop_front()));
        end
        if (done) n_done++;
        exec_done  = stray;
        fetch_done = 1'b0;
        if (exec_cnt > 0) begin
            exec_cnt--;
            if (exec_cnt == 0) exec_done = 1'b1;
        end
        if (fetch_cnt > 0) begin
            fetch_cnt--;
            if (fetch_cnt == 0) begin
                fetch_done  = 1'b1;
                fetch_instr = prog[fetch_a[8:3]];
            end
        end
    endtask

    task automatic pulse_start(input logic [AW-1:0] pc);
        start_pc = pc;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start_pc = '0; step_mode = 1'b0;
        fetch_done = 1'b0; fetch_instr = '0; exec_done = 1'b0;
        f_mem_req = 1'b0; f_mem_addr = '0; e_mem_req = 1'b0; e_mem_we = 1'b0;
        e_mem_addr = '0; e_mem_wdata = '0;
        for (int i = 0; i < 64; i++) prog[i] = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", 64'(busy), 0);
        check("rst_fetch_en", 64'(fetch_en), 0);
        check("rst_trap", 64'(trap), 0);
        check("rst_retired", 64'(retired_count), 0);
        check("rst_mem_we", 64'(mem_we), 0);

        // T1: straight-line program, exec_done 5 cycles after each start
        put(0, mk(LOAD_V, 8'h01), 1); put(8, mk(GEMV, 8'h02), 1);
        put(16, mk(STORE, 8'h03), 1); put(24, '0, 0);
        exp_addr_q = '{24'h0, 24'h8, 24'h10, 24'h18};
        base_e = n_exec; base_d = n_done;
        pulse_start(24'h0);
        for (int i = 0; i < 400 && n_done == base_d; i++) tick();
        check("t1_done", 64'(n_done - base_d), 1);
        check("t1_execs", 64'(n_exec - base_e), 3);
        check("t1_retired", 64'(retired_count), 3);
        check("t1_addrs_left", 64'(exp_addr_q.size()), 0);
        repeat (10) tick();
        check("t1_done_once", 64'(n_done - base_d), 1);
        check("t1_idle", 64'(busy), 0);

        // T2: long execution, queue fills to PQ_DEPTH, start in RUN ignored
        for (int k = 0; k < 6; k++) put(32'h40 + 8 * k, mk(5'(k % 5 + 1), 8'(8'h10 + k)), 1);
        put(32'h70, '0, 0);
        exec_lat = 40;
        base_e = n_exec; base_f = n_fetch; base_d = n_done;
        pulse_start(24'h40);
        for (int i = 0; i < 100 && n_exec == base_e; i++) tick();
        check("t2_first_issue", 64'(n_exec - base_e), 1);
        pulse_start(24'h0);
        repeat (30) tick();
        check("t2_fetches_held", 64'(n_fetch - base_f), 5);
        check("t2_no_fetch_en", 64'(fetch_en), 0);
        for (int i = 0; i < 600 && n_done == base_d; i++) tick();
        check("t2_done", 64'(n_done - base_d), 1);
        check("t2_retired", 64'(retired_count), 6);
        check("t2_total_fetches", 64'(n_fetch - base_f), 7);
        exec_lat = 5;

        // T3: illegal opcode at 0x10, then restart from 0x80
        put(0, mk(LOAD_V, 8'h30), 1); put(8, mk(GEMV, 8'h31), 1);
        put(16, {8'hA5, 40'h0, 8'h32, 3'b000, 5'h1F}, 0); put(24, mk(RELU, 8'h33), 0);
        put(32'h80, mk(RELU, 8'h34), 1); put(32'h88, '0, 0);
        base_e = n_exec; base_d = n_done;
        pulse_start(24'h0);
        for (int i = 0; i < 200 && !trap; i++) tick();
        check("t3_trap", 64'(trap), 1);
        check("t3_trap_pc", 64'(trap_pc), 64'h10);
        check("t3_execs", 64'(n_exec - base_e), 2);
        check("t3_retired", 64'(retired_count), 2);
        check("t3_not_busy", 64'(busy), 0);
        repeat (5) tick();
        check("t3_no_more_exec", 64'(n_exec - base_e), 2);
        pulse_start(24'h80);
        check("t3_trap_cleared", 64'(trap), 0);
        check("t3_retired_cleared", 64'(retired_count), 0);
        for (int i = 0; i < 200 && n_done == base_d; i++) tick();
        check("t3_restart_done", 64'(n_done - base_d), 1);
        check("t3_restart_retired", 64'(retired_count), 1);
        check("t3_queue_empty", 64'(exp_q.size()), 0);

        // T4: single-step, one exec_start per start pulse
        put(32'hC0, mk(LOAD_M, 8'h40), 1); put(32'hC8, mk(RELU, 8'h41), 1);
        put(32'hD0, mk(STORE, 8'h42), 1); put(32'hD8, '0, 0);
        step_mode = 1'b1;
        base_e = n_exec; base_d = n_done;
        pulse_start(24'hC0);
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < 100 && n_exec - base_e < j + 1; i++) tick();
            repeat (20) tick();
            check("t4_one_exec", 64'(n_exec - base_e), 64'(j + 1));
            check("t4_paused_busy", 64'(busy), 1);
            check("t4_retired", 64'(retired_count), 64'(j + 1));
            pulse_start(24'h0);
        end
        for (int i = 0; i < 100 && n_done == base_d; i++) tick();
        check("t4_done", 64'(n_done - base_d), 1);
        check("t4_execs", 64'(n_exec - base_e), 3);
        step_mode = 1'b0;

        // T5: DRAM arbitration
        e_mem_req = 1'b1; e_mem_we = 1'b1; e_mem_addr = 24'h00ABCD; e_mem_wdata = 8'h5A;
        f_mem_req = 1'b1; f_mem_addr = 24'h001234;
        tick();
        check("t5_exec_addr", 64'(mem_addr), 64'h00ABCD);
        check("t5_exec_we", 64'(mem_we), 1);
        check("t5_exec_wdata", 64'(mem_wdata), 64'h5A);
        check("t5_e_valid", 64'(e_mem_valid), 1);
        check("t5_f_blocked", 64'(f_mem_valid), 0);
        e_mem_req = 1'b0;
        tick();
        check("t5_fetch_addr", 64'(mem_addr), 64'h001234);
        check("t5_fetch_we", 64'(mem_we), 0);
        check("t5_f_valid", 64'(f_mem_valid), 1);
        check("t5_e_valid_off", 64'(e_mem_valid), 0);
        f_mem_req = 1'b0;
        tick();
        check("t5_idle_we", 64'(mem_we), 0);
        check("t5_f_valid_off", 64'(f_mem_valid), 0);

        // T6: reset with execution in flight, stray exec_done afterwards
        put(32'h100, mk(GEMV, 8'h60), 1); put(32'h108, mk(RELU, 8'h61), 0); put(32'h110, '0, 0);
        exec_lat = 40;
        base_e = n_exec;
        pulse_start(24'h100);
        for (int i = 0; i < 100 && n_exec == base_e; i++) tick();
        check("t6_issued", 64'(n_exec - base_e), 1);
        repeat (5) tick();
        rst = 1'b1; exec_cnt = 0; fetch_cnt = 0;
        tick();
        check("t6_busy", 64'(busy), 0);
        check("t6_exec_start", 64'(exec_start), 0);
        check("t6_exec_instr", exec_instr, 0);
        check("t6_fetch_en", 64'(fetch_en), 0);
        check("t6_fetch_addr", 64'(fetch_addr), 0);
        check("t6_trap_pc", 64'(trap_pc), 0);
        check("t6_done", 64'(done), 0);
        rst = 1'b0;
        exp_q.delete();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick(); tick();
        check("t6_stray_retired", 64'(retired_count), 0);
        check("t6_idle", 64'(busy), 0);
        check("extra_exec", 64'(n_extra), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
